// File: rtl/arm_pkg.sv
// arm_pkg: definitions shared across the ARM core pipeline.
//   - EXE_CMD encodings driven by the ID-stage control unit into the ALU
//   - instruction mode constants (data-processing, memory, branch)
//   - widths of the shifter-operand and branch-offset fields
package arm_pkg;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_t;

  typedef enum logic [1:0] {
    MODE_DP  = 2'b00,
    MODE_MEM = 2'b01,
    MODE_BR  = 2'b10
  } mode_t;

  localparam int SHIFT_OP_W = 12;
  localparam int SIMM_W     = 24;
  localparam int EXE_CMD_W  = 4;

endpackage

// File: rtl/pipe_field_reg.sv
// pipe_field_reg: W-bit pipeline register with rst > clear > hold > load.
//   clk   in  rising-edge clock
//   rst   in  synchronous active-high reset, loads RST_VAL
//   clear in  loads all zeros (pipeline bubble)
//   hold  in  keeps the current contents (stall)
//   d     in  W  next value when neither rst, clear nor hold is active
//   q     out W  registered value
module pipe_field_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         hold,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (clear) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_exe_reg.sv
// id_exe_reg: ID->EXE pipeline register of the ARM core.
// Captures the decoded control word, operands and register addresses and
// presents them to the EXE stage one cycle later. Priority per edge:
// rst > flush > freeze > load.
//   clk, rst        clock, synchronous active-high reset
//   freeze          hold every output (hazard stall)
//   flush           load a bubble (all-zero stage, valid_out=0)
//   *_in / *_out    control bits, PC+4, operands, immediate fields,
//                   destination/source addresses and carry, registered
//   valid_out       EXE slot holds a real instruction
// Build option: define ID_EXE_FORWARDING_EN to register src1/src2 for the
// forwarding unit; otherwise src1_out/src2_out are tied to 0 and the
// src1_in/src2_in ports are ignored.
module id_exe_reg
  import arm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  flush,
  input  logic [EXE_CMD_W-1:0]  EXE_CMD_in,
  input  logic                  memory_read_en_in,
  input  logic                  memory_write_en_in,
  input  logic                  WB_Enable_in,
  input  logic                  B_in,
  input  logic                  S_in,
  input  logic [DATA_W-1:0]     PC_in,
  input  logic [DATA_W-1:0]     Val_Rn_in,
  input  logic [DATA_W-1:0]     Val_Rm_in,
  input  logic                  imm_in,
  input  logic [SHIFT_OP_W-1:0] shift_operand_in,
  input  logic [SIMM_W-1:0]     signed_imm_24_in,
  input  logic [REG_W-1:0]      Dest_in,
  input  logic [REG_W-1:0]      src1_in,
  input  logic [REG_W-1:0]      src2_in,
  input  logic                  C_in,
  output logic [EXE_CMD_W-1:0]  EXE_CMD_out,
  output logic                  memory_read_en_out,
  output logic                  memory_write_en_out,
  output logic                  WB_Enable_out,
  output logic                  B_out,
  output logic                  S_out,
  output logic [DATA_W-1:0]     PC_out,
  output logic [DATA_W-1:0]     Val_Rn_out,
  output logic [DATA_W-1:0]     Val_Rm_out,
  output logic                  imm_out,
  output logic [SHIFT_OP_W-1:0] shift_operand_out,
  output logic [SIMM_W-1:0]     signed_imm_24_out,
  output logic [REG_W-1:0]      Dest_out,
  output logic [REG_W-1:0]      src1_out,
  output logic [REG_W-1:0]      src2_out,
  output logic                  C_out,
  output logic                  valid_out
);

  // Control group: everything that can change architectural state, plus
  // valid. A bubble zeroes this group so a squashed op has no side effects.
  localparam int CTRL_W = EXE_CMD_W + 6;

  logic [CTRL_W-1:0] ctrl_d;
  logic [CTRL_W-1:0] ctrl_q;

  // valid is loaded as constant 1: any real load is a real instruction.
  assign ctrl_d = {EXE_CMD_in, memory_read_en_in, memory_write_en_in,
                   WB_Enable_in, B_in, S_in, 1'b1};

  pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .hold  (freeze),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  assign {EXE_CMD_out, memory_read_en_out, memory_write_en_out,
          WB_Enable_out, B_out, S_out, valid_out} = ctrl_q;

  // Data group: also cleared on flush so the bubble is fully deterministic.
`ifdef ID_EXE_FORWARDING_EN
  localparam int DATA_GRP_W = 3 * DATA_W + 1 + SHIFT_OP_W + SIMM_W + 3 * REG_W + 1;

  logic [DATA_GRP_W-1:0] data_d;
  logic [DATA_GRP_W-1:0] data_q;

  assign data_d = {PC_in, Val_Rn_in, Val_Rm_in, imm_in, shift_operand_in,
                   signed_imm_24_in, Dest_in, src1_in, src2_in, C_in};

  assign {PC_out, Val_Rn_out, Val_Rm_out, imm_out, shift_operand_out,
          signed_imm_24_out, Dest_out, src1_out, src2_out, C_out} = data_q;
`else
  localparam int DATA_GRP_W = 3 * DATA_W + 1 + SHIFT_OP_W + SIMM_W + REG_W + 1;

  logic [DATA_GRP_W-1:0] data_d;
  logic [DATA_GRP_W-1:0] data_q;

  assign data_d = {PC_in, Val_Rn_in, Val_Rm_in, imm_in, shift_operand_in,
                   signed_imm_24_in, Dest_in, C_in};

  assign {PC_out, Val_Rn_out, Val_Rm_out, imm_out, shift_operand_out,
          signed_imm_24_out, Dest_out, C_out} = data_q;

  // Source addresses only matter to the forwarding unit; without it they
  // are deliberately dropped and the outputs tied off.
  assign src1_out = '0;
  assign src2_out = '0;

  logic unused_src;
  assign unused_src = ^{src1_in, src2_in};
`endif

  pipe_field_reg #(.W(DATA_GRP_W)) u_data_reg (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .hold  (freeze),
    .d     (data_d),
    .q     (data_q)
  );

endmodule

// File: tb/tb_id_exe_reg.sv
// tb_id_exe_reg: self-checking bench for id_exe_reg. Each edge's expected
// output is computed from the rst > flush > freeze > load rules, queued,
// and compared against the DUT 1 ns after the edge. Scenario tasks add
// explicit checks of the values they expect to see.
module tb_id_exe_reg;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        mr;
    logic        mw;
    logic        wb;
    logic        b;
    logic        s;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        c;
    logic        valid;
  } fields_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    freeze = 1'b0;
  logic    flush = 1'b0;
  fields_t in_v = '0;
  fields_t dut_v;
  fields_t model_q = '0;
  fields_t sb[$];

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0]  EXE_CMD_out;
  logic        memory_read_en_out, memory_write_en_out, WB_Enable_out, B_out, S_out;
  logic [31:0] PC_out, Val_Rn_out, Val_Rm_out;
  logic        imm_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
  logic [3:0]  Dest_out, src1_out, src2_out;
  logic        C_out, valid_out;

  always #5 clk = ~clk;

  id_exe_reg #(.DATA_W(32), .REG_W(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .freeze              (freeze),
    .flush               (flush),
    .EXE_CMD_in          (in_v.cmd),
    .memory_read_en_in   (in_v.mr),
    .memory_write_en_in  (in_v.mw),
    .WB_Enable_in        (in_v.wb),
    .B_in                (in_v.b),
    .S_in                (in_v.s),
    .PC_in               (in_v.pc),
    .Val_Rn_in           (in_v.rn),
    .Val_Rm_in           (in_v.rm),
    .imm_in              (in_v.imm),
    .shift_operand_in    (in_v.sh),
    .signed_imm_24_in    (in_v.simm),
    .Dest_in             (in_v.dest),
    .src1_in             (in_v.src1),
    .src2_in             (in_v.src2),
    .C_in                (in_v.c),
    .EXE_CMD_out         (EXE_CMD_out),
    .memory_read_en_out  (memory_read_en_out),
    .memory_write_en_out (memory_write_en_out),
    .WB_Enable_out       (WB_Enable_out),
    .B_out               (B_out),
    .S_out               (S_out),
    .PC_out              (PC_out),
    .Val_Rn_out          (Val_Rn_out),
    .Val_Rm_out          (Val_Rm_out),
    .imm_out             (imm_out),
    .shift_operand_out   (shift_operand_out),
    .signed_imm_24_out   (signed_imm_24_out),
    .Dest_out            (Dest_out),
    .src1_out            (src1_out),
    .src2_out            (src2_out),
    .C_out               (C_out),
    .valid_out           (valid_out)
  );

  assign dut_v = {EXE_CMD_out, memory_read_en_out, memory_write_en_out,
                  WB_Enable_out, B_out, S_out, PC_out, Val_Rn_out, Val_Rm_out,
                  imm_out, shift_operand_out, signed_imm_24_out, Dest_out,
                  src1_out, src2_out, C_out, valid_out};

  // Expected register contents after the next edge.
  function automatic fields_t next_expected(fields_t cur, fields_t inp,
                                            logic r, logic fl, logic fr);
    fields_t n;
    if (r || fl) begin
      n = '0;
    end else if (fr) begin
      n = cur;
    end else begin
      n = inp;
      n.valid = 1'b1;
`ifndef ID_EXE_FORWARDING_EN
      n.src1 = 4'd0;
      n.src2 = 4'd0;
`endif
    end
    return n;
  endfunction

  // Drive current inputs through one edge; expected value queued at drive
  // time, popped and compared once the DUT output has settled.
  task automatic step(input string tag);
    fields_t e;
    e = next_expected(model_q, in_v, rst, flush, freeze);
    model_q = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (dut_v !== e) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, dut_v, e);
    end else begin
      $display("txn %0d %s cmd=%h valid=%b pc=%h", n_vec, tag, dut_v.cmd, dut_v.valid, dut_v.pc);
    end
  endtask

  function automatic fields_t rand_fields();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[155:0];
  endfunction

  task automatic test_reset();
    in_v = '1;
    rst = 1'b1;
    step("reset_0");
    step("reset_1");
    n_vec++;
    if (valid_out !== 1'b0 || PC_out !== 32'd0 || EXE_CMD_out !== 4'd0 || Dest_out !== 4'd0) begin
      n_miss++;
      $display("FAIL reset_zero: got valid=%b pc=%h cmd=%h dest=%h want 0", valid_out, PC_out, EXE_CMD_out, Dest_out);
    end
    rst = 1'b0;
    step("reset_release");
    n_vec++;
    if (valid_out !== 1'b1 || EXE_CMD_out !== 4'hF || PC_out !== 32'hFFFF_FFFF) begin
      n_miss++;
      $display("FAIL reset_first_load: got valid=%b cmd=%h pc=%h want 1 f ffffffff", valid_out, EXE_CMD_out, PC_out);
    end
  endtask

  task automatic test_load();
    in_v = '0;
    in_v.cmd = 4'b0010;
    in_v.wb = 1'b1;
    in_v.rn = 32'h5;
    in_v.rm = 32'h3;
    in_v.dest = 4'd4;
    step("load");
    n_vec++;
    if (EXE_CMD_out !== 4'b0010 || WB_Enable_out !== 1'b1 || Val_Rn_out !== 32'h5 ||
        Val_Rm_out !== 32'h3 || Dest_out !== 4'd4) begin
      n_miss++;
      $display("FAIL load_fields: got cmd=%h wb=%b rn=%h rm=%h dest=%h want 2 1 5 3 4",
               EXE_CMD_out, WB_Enable_out, Val_Rn_out, Val_Rm_out, Dest_out);
    end
  endtask

  task automatic test_freeze();
    in_v = rand_fields();
    in_v.cmd = 4'b0100;
    in_v.s = 1'b1;
    step("freeze_load");
    freeze = 1'b1;
    in_v.cmd = 4'b0110;
    in_v.s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_v.pc = $urandom();
      step("freeze_hold");
    end
    n_vec++;
    if (EXE_CMD_out !== 4'b0100 || S_out !== 1'b1 || valid_out !== 1'b1) begin
      n_miss++;
      $display("FAIL freeze_hold_cmd: got cmd=%h s=%b valid=%b want 4 1 1", EXE_CMD_out, S_out, valid_out);
    end
    freeze = 1'b0;
    step("freeze_release");
    n_vec++;
    if (EXE_CMD_out !== 4'b0110 || S_out !== 1'b0) begin
      n_miss++;
      $display("FAIL freeze_release_cmd: got cmd=%h s=%b want 6 0", EXE_CMD_out, S_out);
    end
  endtask

  task automatic test_flush();
    in_v = rand_fields();
    in_v.mw = 1'b1;
    in_v.wb = 1'b1;
    step("flush_pre");
    flush = 1'b1;
    step("flush");
    n_vec++;
    if (memory_write_en_out !== 1'b0 || WB_Enable_out !== 1'b0 || valid_out !== 1'b0 ||
        PC_out !== 32'd0 || EXE_CMD_out !== 4'd0) begin
      n_miss++;
      $display("FAIL flush_bubble: got mw=%b wb=%b valid=%b pc=%h cmd=%h want all 0",
               memory_write_en_out, WB_Enable_out, valid_out, PC_out, EXE_CMD_out);
    end
    flush = 1'b0;
    step("flush_after");
    n_vec++;
    if (valid_out !== 1'b1 || memory_write_en_out !== 1'b1 || PC_out !== in_v.pc) begin
      n_miss++;
      $display("FAIL flush_reload: got valid=%b mw=%b pc=%h want 1 1 %h", valid_out, memory_write_en_out, PC_out, in_v.pc);
    end
  endtask

  task automatic test_flush_freeze();
    in_v = rand_fields();
    in_v.wb = 1'b1;
    step("ff_pre");
    freeze = 1'b1;
    flush = 1'b1;
    step("ff_both");
    n_vec++;
    if (valid_out !== 1'b0 || WB_Enable_out !== 1'b0) begin
      n_miss++;
      $display("FAIL ff_bubble: got valid=%b wb=%b want 0 0", valid_out, WB_Enable_out);
    end
    flush = 1'b0;
    step("ff_hold");
    n_vec++;
    if (valid_out !== 1'b0 || PC_out !== 32'd0) begin
      n_miss++;
      $display("FAIL ff_bubble_held: got valid=%b pc=%h want 0 0", valid_out, PC_out);
    end
    freeze = 1'b0;
    step("ff_release");
  endtask

  task automatic test_forwarding();
    in_v = rand_fields();
    in_v.src1 = 4'd7;
    in_v.src2 = 4'd9;
    step("fwd");
`ifdef ID_EXE_FORWARDING_EN
    n_vec++;
    if (src1_out !== 4'd7 || src2_out !== 4'd9) begin
      n_miss++;
      $display("FAIL fwd_src: got %0d %0d want 7 9", src1_out, src2_out);
    end
`else
    n_vec++;
    if (src1_out !== 4'd0 || src2_out !== 4'd0) begin
      n_miss++;
      $display("FAIL fwd_src: got %0d %0d want 0 0", src1_out, src2_out);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0] cmds [9];
    cmds = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000};
    for (int i = 0; i < 9; i++) begin
      in_v = rand_fields();
      in_v.cmd = cmds[i];
      step("b2b");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      in_v = rand_fields();
      rst = ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 5) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      step("rand");
    end
    rst = 1'b0;
    flush = 1'b0;
    freeze = 1'b0;
    step("rand_end");
  endtask

  initial begin
    test_reset();
    test_load();
    test_freeze();
    test_flush();
    test_flush_freeze();
    test_forwarding();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
